// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants, FSM state encoding and signedness helpers for the RV32M
// iterative multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] FUNCT7_M     = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic a_is_signed(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_DIV, F3_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Shared 33-bit add/subtract datapath with acc and multiplier/quotient shift
// registers. MULDIV_EARLY_OUT_EN enables the multiply early-out shortcut.
module muldiv_datapath #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [XLEN-1:0]  load_mpl,
    input  logic [XLEN-1:0]  load_mcand,
    input  logic [CNT_W-1:0] cnt,
    output logic [XLEN-1:0]  acc,
    output logic [XLEN-1:0]  mpl,
    output logic             last_step
);

    logic [XLEN-1:0] acc_r, mpl_r, mcand_r;
    logic [XLEN:0]   add_x_s, add_y_s, sum_s;
    logic [XLEN-1:0] acc_n_s, mpl_n_s, acc_nx_s, mpl_nx_s;
    logic            early_s;

    // Single adder: subtract for divide is x + ~y + 1.
    always_comb begin
        if (is_div) begin
            add_x_s = {acc_r, mpl_r[XLEN-1]};
            add_y_s = ~{1'b0, mcand_r};
        end else begin
            add_x_s = {1'b0, acc_r};
            add_y_s = {1'b0, mcand_r};
        end
        sum_s = add_x_s + add_y_s + {{XLEN{1'b0}}, is_div};
    end

    // One iteration: restoring-divide step or shift-add multiply step.
    always_comb begin
        acc_n_s = acc_r;
        mpl_n_s = mpl_r;
        if (is_div) begin
            if (!sum_s[XLEN]) begin
                acc_n_s = sum_s[XLEN-1:0];
                mpl_n_s = {mpl_r[XLEN-2:0], 1'b1};
            end else begin
                acc_n_s = add_x_s[XLEN-1:0];
                mpl_n_s = {mpl_r[XLEN-2:0], 1'b0};
            end
        end else if (mpl_r[0]) begin
            {acc_n_s, mpl_n_s} = {sum_s, mpl_r[XLEN-1:1]};
        end else begin
            {acc_n_s, mpl_n_s} = {1'b0, acc_r, mpl_r[XLEN-1:1]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0]  rem_cnt_s;
    logic [XLEN-1:0]   mask_s;
    logic [2*XLEN-1:0] shifted_s;

    // Once the unconsumed multiplier bits are zero, the rest is a plain shift.
    always_comb begin
        rem_cnt_s = CNT_W'(XLEN-1) - cnt;
        mask_s    = ({{(XLEN-1){1'b0}}, 1'b1} << rem_cnt_s) - {{(XLEN-1){1'b0}}, 1'b1};
        shifted_s = {acc_n_s, mpl_n_s} >> rem_cnt_s;
        early_s   = !is_div && ((mpl_n_s & mask_s) == {XLEN{1'b0}});
        if (early_s) begin
            acc_nx_s = shifted_s[2*XLEN-1:XLEN];
            mpl_nx_s = shifted_s[XLEN-1:0];
        end else begin
            acc_nx_s = acc_n_s;
            mpl_nx_s = mpl_n_s;
        end
    end
`else
    // Fixed-latency build: always take the plain iteration result.
    always_comb begin
        early_s  = 1'b0;
        acc_nx_s = acc_n_s;
        mpl_nx_s = mpl_n_s;
    end
`endif

    assign last_step = (cnt == CNT_W'(XLEN-1)) | early_s;
    assign acc       = acc_r;
    assign mpl       = mpl_r;

    // Operand registers: loaded at issue, advanced once per iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {XLEN{1'b0}};
            mpl_r   <= {XLEN{1'b0}};
            mcand_r <= {XLEN{1'b0}};
        end else if (load) begin
            acc_r   <= {XLEN{1'b0}};
            mpl_r   <= load_mpl;
            mcand_r <= load_mcand;
        end else if (step) begin
            acc_r   <= acc_nx_s;
            mpl_r   <= mpl_nx_s;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide sequencer for the EX stage; stalls the
// pipeline while running. MULDIV_EARLY_OUT_EN shortens multiplies.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    state_t             state_r, state_n_s;
    logic [CNT_W-1:0]   cnt_r, cnt_n_s;
    logic [2:0]         funct3_r;
    logic               sign_a_r, sign_b_r;
    logic [XLEN-1:0]    result_r, result_n_s;
    logic               load_s, step_s, last_step_s;
    logic               a_sgn_s, b_sgn_s, special_s;
    logic [XLEN-1:0]    a_abs_s, b_abs_s, special_val_s, fix_val_s;
    logic [XLEN-1:0]    load_mpl_s, load_mcand_s, acc_s, mpl_s;
    logic [2*XLEN-1:0]  prod_fix_s;

    // Issue-time decode: operand magnitudes, signs and divide special cases.
    always_comb begin
        a_sgn_s = a_is_signed(funct3) & op_a[XLEN-1];
        b_sgn_s = b_is_signed(funct3) & op_b[XLEN-1];
        a_abs_s = a_sgn_s ? -op_a : op_a;
        b_abs_s = b_sgn_s ? -op_b : op_b;
        if (funct3[2]) begin
            load_mpl_s   = a_abs_s;
            load_mcand_s = b_abs_s;
        end else begin
            load_mpl_s   = b_abs_s;
            load_mcand_s = a_abs_s;
        end
        special_s     = 1'b0;
        special_val_s = {XLEN{1'b0}};
        if (funct3[2] && (op_b == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? op_a : {XLEN{1'b1}};
        end else if ((funct3 == F3_DIV || funct3 == F3_REM) &&
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}})) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            special_s     = 1'b0;
            special_val_s = {XLEN{1'b0}};
        end
    end

    // Sign fix-up: remainder follows the dividend, everything else sign(a)^sign(b).
    always_comb begin
        prod_fix_s = (sign_a_r ^ sign_b_r) ? -{acc_s, mpl_s} : {acc_s, mpl_s};
        case (funct3_r)
            F3_MUL:                        fix_val_s = prod_fix_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_val_s = prod_fix_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_val_s = (sign_a_r ^ sign_b_r) ? -mpl_s : mpl_s;
            F3_REM, F3_REMU:               fix_val_s = sign_a_r ? -acc_s : acc_s;
            default:                       fix_val_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state and handshake outputs; kill wins in every state.
    always_comb begin
        state_n_s    = state_r;
        cnt_n_s      = cnt_r;
        result_n_s   = result_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (kill) begin
                    state_n_s = S_IDLE;
                end else if (start) begin
                    stall   = 1'b1;
                    load_s  = 1'b1;
                    cnt_n_s = {CNT_W{1'b0}};
                    if (special_s) begin
                        state_n_s  = S_DONE;
                        result_n_s = special_val_s;
                    end else begin
                        state_n_s  = S_ITER;
                    end
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_ITER: begin
                if (kill) begin
                    state_n_s = S_IDLE;
                end else begin
                    stall  = 1'b1;
                    step_s = 1'b1;
                    if (last_step_s) begin
                        state_n_s = S_FIX;
                    end else begin
                        state_n_s = S_ITER;
                        cnt_n_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_n_s = S_IDLE;
                end else begin
                    stall      = 1'b1;
                    result_n_s = fix_val_s;
                    state_n_s  = S_DONE;
                end
            end
            S_DONE: begin
                state_n_s = S_IDLE;
                if (kill) begin
                    result_valid = 1'b0;
                end else begin
                    result_valid = 1'b1;
                end
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_r != S_IDLE);
    assign result = result_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Iteration counter, latched op descriptor and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            funct3_r <= 3'b000;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            cnt_r    <= cnt_n_s;
            result_r <= result_n_s;
            if (load_s) begin
                funct3_r <= funct3;
                sign_a_r <= a_sgn_s;
                sign_b_r <= b_sgn_s;
            end
        end
    end

    muldiv_datapath #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .step       (step_s),
        .is_div     (load_s ? funct3[2] : funct3_r[2]),
        .load_mpl   (load_mpl_s),
        .load_mcand (load_mcand_s),
        .cnt        (cnt_r),
        .acc        (acc_s),
        .mpl        (mpl_s),
        .last_step  (last_step_s)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, corner sequences
// and randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, result_valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_cyc;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    muldiv_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .kill         (kill),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint unsigned pu;
        longint          ps;
        int              sa, sb;
        logic            ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            F3_MUL:    begin pu = 64'(a) * 64'(b); return pu[31:0]; end
            F3_MULH:   begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
            F3_MULHSU: begin ps = longint'(sa) * longint'({32'd0, b}); return ps[63:32]; end
            F3_MULHU:  begin pu = 64'(a) * 64'(b); return pu[63:32]; end
            F3_DIV:    return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            F3_REM:    return (b == 32'd0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int          k;
        m = b;
        k = 1;
        if (f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2]) begin
            if (f3 == F3_MULH && b[31]) m = -b;
            for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
            return 3 + k;
        end
`endif
        return 35 + 0 * (k + int'(m[0]));
    endfunction

    // Issue one op at posedge+1; returns at posedge+1 after its DONE cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int          c, sc, lat;
        logic        got;
        logic [31:0] res;
        lat = model_lat(f3, a, b);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        c = 0; sc = 0; got = 1'b0; res = 'x;
        while (!got && c < 100) begin
            @(negedge clk);
            c++;
            if (stall) sc++;
            if (result_valid) begin
                got = 1'b1; res = result; valid_cyc = cyc;
            end
            @(posedge clk); #1;
            if (!got) begin
                op_a = $urandom; op_b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        chk({name, "_valid_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_result"}, res, exp);
        chk({name, "_latency"}, 32'(c), 32'(lat));
        chk({name, "_stall_cycles"}, 32'(sc), 32'(lat - 1));
    endtask

    initial begin
        int          t1;
        logic        saw;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs.push_back('{F3_MUL,    32'h0000_0006, 32'hFFFF_FFFD, 32'hFFFF_FFEE, "mul_6x-3"});
        vecs.push_back('{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min"});
        vecs.push_back('{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff"});
        vecs.push_back('{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff"});
        vecs.push_back('{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_-7_2"});
        vecs.push_back('{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_-7_2"});
        vecs.push_back('{F3_DIVU,   32'd100,       32'd7,         32'd14,        "divu_100_7"});
        vecs.push_back('{F3_REMU,   32'd100,       32'd7,         32'd2,         "remu_100_7"});
        vecs.push_back('{F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, "div_by0"});
        vecs.push_back('{F3_REM,    32'd5,         32'd0,         32'd5,         "rem_by0"});
        vecs.push_back('{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
        vecs.push_back('{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf"});
        vecs.push_back('{F3_MULU_OR_MUL_SMALL(), 32'd7, 32'd3,    32'd21,        "mul_7x3"});

        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'b000; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // Back-to-back MUL then DIV with no idle cycle between.
        run_op(F3_MUL, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFEE, "b2b_mul");
        t1 = valid_cyc;
        run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "b2b_div");
        chk("b2b_gap", 32'(valid_cyc - t1), 32'(model_lat(F3_DIV, 32'hFFFF_FFF9, 32'd2)));

        // kill at ITER cycle 10.
        funct3 = F3_DIVU; op_a = 32'hFFFF_FFFF; op_b = 32'd3; start = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk); if (result_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("kill_busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1; start = 1'b0;
        @(negedge clk); if (result_valid) saw = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_idle_busy", {31'd0, busy}, 32'd0);
        chk("kill_idle_stall", {31'd0, stall}, 32'd0);
        repeat (40) begin
            @(negedge clk); if (result_valid) saw = 1'b1;
        end
        chk("kill_no_valid", {31'd0, saw}, 32'd0);
        @(posedge clk); #1;
        run_op(F3_DIVU, 32'd9, 32'd3, 32'd3, "after_kill_divu");

        // kill during DONE of a special-case op.
        funct3 = F3_DIV; op_a = 32'd5; op_b = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_stall", {31'd0, stall}, 32'd0);
        kill = 1'b1;
        #2;
        chk("kill_done_valid", {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("kill_done_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of ITER.
        funct3 = F3_REMU; op_a = 32'd1234567; op_b = 32'd89; start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(F3_REMU, 32'd1234567, 32'd89, model(F3_REMU, 32'd1234567, 32'd89), "after_rst_remu");

        // Randomized ops against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'hFFFF_FFFF;
                3:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h8000_0000;
                3:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(rf, ra, rb, model(rf, ra, rb), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic [2:0] F3_MULU_OR_MUL_SMALL();
        return F3_MULHU ^ 3'b011;
    endfunction

endmodule
